writeback_unit: RTL and testbench

//  Write-back stage driving the register_file write side: accepts ALU and load results over valid/ready,

---
 rtl/arm_core_pkg.sv | 22 ++
 rtl/wb_scoreboard.sv | 45 ++++
 rtl/writeback_unit.sv | 138 +++++++++++++
 tb/tb_writeback_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_core_pkg.sv
// Shared constants and the write-back beat type used by the write-back stage
// and its busy-register scoreboard.
package arm_core_pkg;

  localparam int WORD_SIZE  = 32;
  localparam int NUM_REGS   = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int STARVE_MAX = 2;

  // Register index 15 is the program counter; writes to it go to the PC port.
  localparam logic [ADDR_WIDTH-1:0] PC_IDX = 4'd15;

  // One result travelling from a producer (ALU or load) into the register file.
  typedef struct packed {
    logic                  rd_we;
    logic [ADDR_WIDTH-1:0] rd;
    logic [WORD_SIZE-1:0]  data;
    logic                  cpsr_we;
    logic [WORD_SIZE-1:0]  cpsr;
  } wb_beat_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register busy scoreboard: issue reserves a destination, write-back
// retires it. A reservation landing on a register that is still pending
// (and not retiring in the same cycle) latches a sticky error.
module wb_scoreboard
  import arm_core_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rsv_valid,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  input  logic                  clr_valid,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  wb_err
);

  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] busy_next;
  logic                err_hit;

  // Next busy state: retire first, then reserve, so a same-cycle reserve of
  // the retiring index leaves the bit set for the newer reservation.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (rsv_valid) set_vec[rsv_addr] = 1'b1;
    if (clr_valid) clr_vec[clr_addr] = 1'b1;
    busy_next = (busy_mask & ~clr_vec) | set_vec;
    err_hit   = rsv_valid && busy_mask[rsv_addr] &&
                !(clr_valid && (clr_addr == rsv_addr));
  end

  // Busy bits and the sticky double-reservation flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_mask <= '0;
      wb_err    <= 1'b0;
    end else begin
      busy_mask <= busy_next;
      if (err_hit) wb_err <= 1'b1;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: arbitrates ALU and load results (valid/ready) and issues
// one registered register/PC/CPSR write per cycle, one cycle after accept.
// Optional operand bypass outputs are enabled by defining WRITEBACK_FWD_EN.
//
// Handshake: a beat transfers in a cycle where valid && ready are both high.
// ready depends only on the valid inputs, the starvation counter and reset;
// it never depends on the data being offered.
module writeback_unit
  import arm_core_pkg::*;
#(
  parameter int STARVE_MAX_P = STARVE_MAX
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic                  alu_rd_we,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [WORD_SIZE-1:0]  alu_data,
  input  logic                  alu_cpsr_we,
  input  logic [WORD_SIZE-1:0]  alu_cpsr,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [WORD_SIZE-1:0]  mem_data,
  input  logic                  rsv_valid,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  rd_we,
  output logic [ADDR_WIDTH-1:0] write_rd,
  output logic [WORD_SIZE-1:0]  rd_in,
  output logic                  pc_we,
  output logic [WORD_SIZE-1:0]  pc_in,
  output logic                  cpsr_we,
  output logic [WORD_SIZE-1:0]  cpsr_in,
`ifdef WRITEBACK_FWD_EN
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_addr,
  output logic [WORD_SIZE-1:0]  fwd_data,
`endif
  output logic                  wb_err
);

  localparam int CNT_W = (STARVE_MAX_P < 1) ? 1 : $clog2(STARVE_MAX_P + 1);

  // Consecutive MEM grants the ALU has sat through while offering a beat.
  logic [CNT_W-1:0] starve_cnt;
  logic             alu_starved;
  logic             alu_grant;
  logic             mem_grant;
  logic             beat_valid;
  wb_beat_t         beat;
  logic             retire_en;

  // Grant selection: loads win unless the ALU has waited long enough.
  always_comb begin
    alu_starved = (starve_cnt >= CNT_W'(STARVE_MAX_P));
    alu_grant   = !reset && alu_valid && (!mem_valid || alu_starved);
    mem_grant   = !reset && mem_valid && !(alu_valid && alu_starved);
    beat_valid  = alu_grant || mem_grant;
    beat        = '0;
    if (alu_grant) begin
      beat.rd_we   = alu_rd_we;
      beat.rd      = alu_rd;
      beat.data    = alu_data;
      beat.cpsr_we = alu_cpsr_we;
      beat.cpsr    = alu_cpsr;
    end else if (mem_grant) begin
      beat.rd_we   = 1'b1;
      beat.rd      = mem_rd;
      beat.data    = mem_data;
    end
    retire_en = beat_valid && beat.rd_we;
  end

  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;

`ifdef WRITEBACK_FWD_EN
  // Bypass view of the beat being accepted now, a cycle ahead of rd_we.
  assign fwd_valid = retire_en;
  assign fwd_addr  = beat.rd;
  assign fwd_data  = beat.data;
`endif

  // Starvation counter: counts MEM grants only while the ALU is waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (alu_grant || !alu_valid) begin
      starve_cnt <= '0;
    end else if (mem_grant) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Registered write strobes: high for exactly the cycle after the accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_we    <= 1'b0;
      write_rd <= '0;
      rd_in    <= '0;
      pc_we    <= 1'b0;
      pc_in    <= '0;
      cpsr_we  <= 1'b0;
      cpsr_in  <= '0;
    end else begin
      rd_we   <= retire_en && (beat.rd != PC_IDX);
      pc_we   <= retire_en && (beat.rd == PC_IDX);
      cpsr_we <= beat_valid && beat.cpsr_we;
      if (retire_en && (beat.rd != PC_IDX)) begin
        write_rd <= beat.rd;
        rd_in    <= beat.data;
      end
      if (retire_en && (beat.rd == PC_IDX)) begin
        pc_in <= beat.data;
      end
      if (beat_valid && beat.cpsr_we) begin
        cpsr_in <= beat.cpsr;
      end
    end
  end

  // Busy tracking: the accepted beat retires its destination at the same
  // edge that raises its write strobe.
  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .clr_valid (retire_en),
    .clr_addr  (beat.rd),
    .busy_mask (busy_mask),
    .wb_err    (wb_err)
  );

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: a cycle model of the write-back
// rules checked every cycle, plus directed vectors with literal expectations.
module tb_writeback_unit;
  import arm_core_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                  alu_valid, alu_ready, alu_rd_we, alu_cpsr_we;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [WORD_SIZE-1:0]  alu_data, alu_cpsr;
  logic                  mem_valid, mem_ready;
  logic [ADDR_WIDTH-1:0] mem_rd;
  logic [WORD_SIZE-1:0]  mem_data;
  logic                  rsv_valid;
  logic [ADDR_WIDTH-1:0] rsv_addr;
  logic [NUM_REGS-1:0]   busy_mask;
  logic                  rd_we, pc_we, cpsr_we, wb_err;
  logic [ADDR_WIDTH-1:0] write_rd;
  logic [WORD_SIZE-1:0]  rd_in, pc_in, cpsr_in;
`ifdef WRITEBACK_FWD_EN
  logic                  fwd_valid;
  logic [ADDR_WIDTH-1:0] fwd_addr;
  logic [WORD_SIZE-1:0]  fwd_data;
`endif

  writeback_unit dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd_we(alu_rd_we),
    .alu_rd(alu_rd), .alu_data(alu_data), .alu_cpsr_we(alu_cpsr_we),
    .alu_cpsr(alu_cpsr),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd),
    .mem_data(mem_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .busy_mask(busy_mask),
    .rd_we(rd_we), .write_rd(write_rd), .rd_in(rd_in),
    .pc_we(pc_we), .pc_in(pc_in), .cpsr_we(cpsr_we), .cpsr_in(cpsr_in),
`ifdef WRITEBACK_FWD_EN
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
`endif
    .wb_err(wb_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Model state is "what the DUT must show after the next rising edge".
  logic        m_wr, m_cpsr_we, m_err;
  logic [3:0]  m_dest;
  logic [31:0] m_data, m_cpsr;
  logic [15:0] m_busy;
  int          m_streak;       // MEM grants the waiting ALU has sat through
  logic        g_alu, g_mem;   // grants decided for the coming edge
  logic        log_en = 1'b0;
  byte         glog[$];
  logic [35:0] wlog[$];

  always @(negedge clk) begin
    if (reset) begin
      check("rst_rd_we", rd_we, 0);
      check("rst_pc_we", pc_we, 0);
      check("rst_cpsr_we", cpsr_we, 0);
      check("rst_busy", busy_mask, 0);
      check("rst_err", wb_err, 0);
      check("rst_alu_ready", alu_ready, 0);
      check("rst_mem_ready", mem_ready, 0);
      m_wr = 0; m_cpsr_we = 0; m_err = 0; m_dest = 0; m_data = 0; m_cpsr = 0;
      m_busy = 0; m_streak = 0; g_alu = 0; g_mem = 0;
    end else begin
      // Outputs produced by the previous cycle's accepted beat.
      check("rd_we", rd_we, m_wr && (m_dest != 4'd15));
      if (m_wr && m_dest != 4'd15) begin
        check("write_rd", write_rd, m_dest);
        check("rd_in", rd_in, m_data);
      end
      check("pc_we", pc_we, m_wr && (m_dest == 4'd15));
      if (m_wr && m_dest == 4'd15) check("pc_in", pc_in, m_data);
      check("cpsr_we", cpsr_we, m_cpsr_we);
      if (m_cpsr_we) check("cpsr_in", cpsr_in, m_cpsr);
      check("busy_mask", busy_mask, m_busy);
      check("wb_err", wb_err, m_err);

      // Who is served at the coming edge.
      g_alu = alu_valid && (!mem_valid || m_streak >= STARVE_MAX);
      g_mem = mem_valid && !g_alu;
      check("alu_ready", alu_ready, g_alu);
      check("mem_ready", mem_ready, g_mem);
      if (log_en && g_alu) glog.push_back(8'h41);
      if (log_en && g_mem) glog.push_back(8'h4D);
      if (log_en && rd_we) wlog.push_back({write_rd, rd_in});

      m_streak = (alu_valid && g_mem) ? m_streak + 1 : 0;
      m_wr = 0; m_cpsr_we = 0;
      if (g_alu) begin
        m_wr = alu_rd_we; m_dest = alu_rd; m_data = alu_data;
        m_cpsr_we = alu_cpsr_we; m_cpsr = alu_cpsr;
      end else if (g_mem) begin
        m_wr = 1; m_dest = mem_rd; m_data = mem_data;
      end
`ifdef WRITEBACK_FWD_EN
      check("fwd_valid", fwd_valid, m_wr);
      if (m_wr) begin
        check("fwd_addr", fwd_addr, m_dest);
        check("fwd_data", fwd_data, m_data);
      end
`endif
      // Scoreboard: retire the written register, then apply the reservation.
      if (rsv_valid && m_busy[rsv_addr] && !(m_wr && m_dest == rsv_addr)) m_err = 1;
      if (m_wr) m_busy[m_dest] = 1'b0;
      if (rsv_valid) m_busy[rsv_addr] = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    alu_valid = 0; alu_rd_we = 0; alu_rd = 0; alu_data = 0;
    alu_cpsr_we = 0; alu_cpsr = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    rsv_valid = 0; rsv_addr = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic alu_beat(input logic we, input logic [3:0] rd, input logic [31:0] d,
                          input logic cwe, input logic [31:0] c);
    alu_valid = 1; alu_rd_we = we; alu_rd = rd; alu_data = d;
    alu_cpsr_we = cwe; alu_cpsr = c;
  endtask

  // ---------------- directed stimulus ----------------
  logic [35:0] exp_q[$];
  string       exp_grants;
  int          ai, mi;

  initial begin
    reset = 1'b1;
    idle();
    repeat (3) next_cycle();
    reset = 1'b0;
    repeat (2) next_cycle();

    // 1: ALU-only write, visible exactly one cycle later for one cycle.
    alu_beat(1, 4'd3, 32'hDEAD_BEEF, 0, 0);
    next_cycle();
    idle();
    at_neg();
    check("t1_rd_we", rd_we, 1);
    check("t1_write_rd", write_rd, 3);
    check("t1_rd_in", rd_in, 32'hDEAD_BEEF);
    at_neg();
    check("t1_rd_we_drop", rd_we, 0);
    next_cycle();

    // 3: ALU write to the PC.
    alu_beat(1, 4'd15, 32'h100, 0, 0);
    next_cycle();
    idle();
    at_neg();
    check("t3_pc_we", pc_we, 1);
    check("t3_pc_in", pc_in, 32'h100);
    check("t3_rd_we", rd_we, 0);
    next_cycle();

    // 5: flags-only compare.
    alu_beat(0, 4'd7, 32'h1234, 1, 32'h6000_0000);
    next_cycle();
    idle();
    at_neg();
    check("t5_cpsr_we", cpsr_we, 1);
    check("t5_cpsr_in", cpsr_in, 32'h6000_0000);
    check("t5_rd_we", rd_we, 0);
    check("t5_pc_we", pc_we, 0);
    next_cycle();

    // 2: both producers always valid -> MEM,MEM,ALU,MEM,MEM,ALU.
    ai = 0; mi = 0;
    alu_beat(1, 4'd1, 32'hA0, 0, 0);
    mem_valid = 1; mem_rd = 4'd2; mem_data = 32'hB0;
    log_en = 1;
    repeat (6) begin
      next_cycle();
      if (g_alu) begin ai++; alu_data = 32'hA0 + 32'(ai); end
      if (g_mem) begin mi++; mem_data = 32'hB0 + 32'(mi); end
    end
    idle();
    at_neg();
    log_en = 0;
    exp_grants = "MMAMMA";
    check("t2_grant_count", 36'(glog.size()), 6);
    for (int i = 0; i < 6; i++)
      if (i < glog.size()) check("t2_grant", 36'(glog[i]), 36'(exp_grants[i]));
    exp_q.push_back({4'd2, 32'hB0}); exp_q.push_back({4'd2, 32'hB1});
    exp_q.push_back({4'd1, 32'hA0}); exp_q.push_back({4'd2, 32'hB2});
    exp_q.push_back({4'd2, 32'hB3}); exp_q.push_back({4'd1, 32'hA1});
    check("t2_write_count", 36'(wlog.size()), 6);
    for (int i = 0; i < 6; i++)
      if (i < wlog.size()) check("t2_write", wlog[i], exp_q[i]);
    next_cycle();

    // 4: scoreboard reserve / retire / double reserve.
    rsv_valid = 1; rsv_addr = 4'd5;                       // T
    next_cycle();
    rsv_valid = 0;                                         // T+1
    at_neg();
    check("t4_busy_t1", busy_mask[5], 1);
    next_cycle();
    mem_valid = 1; mem_rd = 4'd5; mem_data = 32'h55;       // T+2
    at_neg();
    check("t4_busy_t2", busy_mask[5], 1);
    next_cycle();
    idle();                                                // T+3
    at_neg();
    check("t4_busy_t3", busy_mask[5], 0);
    check("t4_write_rd", write_rd, 5);
    next_cycle();
    rsv_valid = 1; rsv_addr = 4'd5;                        // reserve + write r5
    mem_valid = 1; mem_rd = 4'd5; mem_data = 32'h56;
    next_cycle();
    idle();
    rsv_valid = 1; rsv_addr = 4'd5;                        // reserve while busy
    at_neg();
    check("t4_busy_same_cycle", busy_mask[5], 1);
    check("t4_err_before", wb_err, 0);
    next_cycle();
    idle();
    at_neg();
    check("t4_err_set", wb_err, 1);
    repeat (3) next_cycle();
    check("t4_err_sticky", wb_err, 1);

    // 6: reset in the middle of a burst.
    mem_valid = 1; mem_rd = 4'd6; mem_data = 32'h66;
    rsv_valid = 1; rsv_addr = 4'd9;
    next_cycle();
    rsv_valid = 0; mem_data = 32'h67;
    next_cycle();
    reset = 1'b1;
    #1;
    check("t6_rd_we", rd_we, 0);
    check("t6_busy", busy_mask, 0);
    check("t6_err", wb_err, 0);
    check("t6_mem_ready", mem_ready, 0);
    next_cycle();
    idle();
    reset = 1'b0;
    alu_beat(1, 4'd4, 32'h44, 0, 0);
    next_cycle();
    idle();
    at_neg();
    check("t6_first_rd_we", rd_we, 1);
    check("t6_first_write_rd", write_rd, 4);
    check("t6_first_rd_in", rd_in, 32'h44);
    check("t6_first_busy", busy_mask, 0);
    repeat (2) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: run did not complete, time %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
